demux_rr_distributor: RTL

Sequential serial-to-parallel distributor that sits directly upstream of the 1:N demux and replaces its static select. It accepts a stream of single-bit beats over a valid/ready handshake and steers each beat to the next output channel in round-robin order. It latches the beats into an N-bit frame register and presents the completed frame to the downstream consumer under a second valid/ready handshake. It also exports the live select so a combinational 1:N demux can be driven in lockstep.

---
 rtl/demux_pkg.sv | 14 +
 rtl/rr_sel_counter.sv | 42 ++++
 rtl/demux_rr_distributor.sv | 112 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin serial-to-parallel distributor.
package demux_pkg;

    // Width of the wrapping consumed-frame counter.
    localparam int FRAMES_W = 8;

    // Distributor FSM states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } dstate_t;

endpackage

// File: rtl/rr_sel_counter.sv
// Modulo-N round-robin select counter with synchronous clear.
// wrap flags the increment that takes the count from N-1 back to 0.
module rr_sel_counter #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] sel,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    assign wrap = inc && (sel_q == LAST);
    assign sel  = sel_q;

    // Next count: clear wins, otherwise step and wrap at N-1 so values >= N never occur.
    always_comb begin
        sel_d = sel_q;
        if (clr) begin
            sel_d = '0;
        end else if (inc) begin
            sel_d = wrap ? '0 : sel_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/demux_rr_distributor.sv
// Round-robin serial-to-parallel distributor.
// Handshakes: a beat moves when d_valid & d_ready on a rising edge; a frame moves
// when out_valid & out_ready on a rising edge. d_ready only depends on the FSM
// state and en; out_valid is registered. A producer seeing d_ready low must hold
// its beat, and the frame in y is frozen while out_valid waits for out_ready.
module demux_rr_distributor
    import demux_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                d_in,
    input  logic                d_valid,
    output logic                d_ready,
    output logic [SEL_W-1:0]    sel,
    output logic [N-1:0]        y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FRAMES_W-1:0] frames,
    output logic [1:0]          dbg_state
);

    dstate_t             state_q;
    logic [N-1:0]        y_q;
    logic                out_valid_q;
    logic [FRAMES_W-1:0] frames_q;

    logic         fill_st;
    logic         accept;
    logic         cnt_clr;
    logic         wrap;
    logic [N-1:0] y_upd;

    assign fill_st = (state_q == FILL);
    assign d_ready = fill_st & en;
    assign accept  = d_ready & d_valid;
    // Dropping en mid-fill discards the partial frame, so the select restarts at 0.
    assign cnt_clr = fill_st & ~en;

    rr_sel_counter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (accept),
        .sel   (sel),
        .wrap  (wrap)
    );

    // Frame register with the current beat written into the slot named by sel.
    always_comb begin
        y_upd = y_q;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                y_upd[k] = d_in;
            end
        end
    end

    // Distributor FSM: fill frame bits, hold the completed frame, count consumed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            frames_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (!en) begin
                        state_q <= IDLE;
                        y_q     <= '0;
                    end else if (d_valid) begin
                        y_q <= y_upd;
                        if (wrap) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // en is ignored here so a finished frame is always delivered.
                    if (out_ready) begin
                        frames_q    <= frames_q + 1'b1;
                        y_q         <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= en ? FILL : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign frames    = frames_q;
    assign dbg_state = state_q;

endmodule
